muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit sitting beside the ALU, downstream of the register file.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_datapath.sv | 115 +++++++++++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 operation codes (OP_*)
//   - FSM state encoding (state_e)
//   - default operand width (XLEN_DEF)
//   - small decode helpers that classify an operation
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // rs1 is treated as two's complement.
  function automatic logic op1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement.
  function automatic logic op2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Datapath of the multiply/divide unit: 2*XLEN accumulator, radix-2
// shift-add / restoring shift-subtract step, operand magnitudes and final
// sign correction.
// Ports:
//   clk_i      clock
//   load_i     capture operands into the accumulator (start of operation)
//   step_i     perform one iteration
//   ld_op_i    funct3 presented with the operands at load time
//   op1_i      rs1 value (valid with load_i)
//   op2_i      rs2 value (valid with load_i)
//   op_i       funct3 of the operation in flight
//   neg_i      captured result-negate flag of the operation in flight
//   neg_o      result-negate flag derived from the load-time operands
//   special_o  load-time operands form divide-by-zero or signed overflow
//   result_o   sign-corrected result of the accumulator's next value
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [2:0]      ld_op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [2:0]      op_i,
  input  logic            neg_i,
  output logic            neg_o,
  output logic            special_o,
  output logic [XLEN-1:0] result_o
);

  // {hi, lo}: multiply = {partial product, multiplier}; divide = {remainder, quotient}
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;

  logic            a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_neg = op1_signed(ld_op_i) & op1_i[XLEN-1];
  assign b_neg = op2_signed(ld_op_i) & op2_i[XLEN-1];
  assign a_mag = a_neg ? -op1_i : op1_i;
  assign b_mag = b_neg ? -op2_i : op2_i;

  assign div0 = is_div(ld_op_i) && (op2_i == '0);
  assign ovf  = ((ld_op_i == OP_DIV) || (ld_op_i == OP_REM)) &&
                (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == {XLEN{1'b1}});

  assign special_o = div0 | ovf;
  // Special cases are preloaded with their final values, so they are never negated.
  assign neg_o = special_o ? 1'b0 :
                 (ld_op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);

  // Multiply step: add multiplicand into the high half when the multiplier
  // LSB is set, then shift the whole accumulator right keeping the carry.
  logic [XLEN:0]     mul_hi;
  logic [2*XLEN-1:0] mul_next;
  assign mul_hi   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_hi, acc_q[XLEN-1:1]};

  // Restoring divide step: shift left, trial-subtract the divisor from the
  // XLEN+1-bit partial remainder, keep the difference if it did not borrow.
  logic [XLEN:0]     div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load_i) begin
      opnd_d = b_mag;
      // Divide-by-zero: quotient all ones, remainder the raw dividend.
      // Signed overflow: quotient is the most negative value, remainder 0.
      if (div0) begin
        acc_d = {op1_i, {XLEN{1'b1}}};
      end else if (ovf) begin
        acc_d = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
      end else begin
        acc_d = {{XLEN{1'b0}}, a_mag};
      end
    end else if (step_i) begin
      acc_d = is_div(op_i) ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk_i) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
  end

  // Result is formed from the next accumulator value so it is final on the
  // same edge that performs the last iteration.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  assign prod_s = neg_i ? -acc_d : acc_d;
  assign quo_s  = neg_i ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
  assign rem_s  = neg_i ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_MUL:                         result_o = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   result_o = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                result_o = quo_s;
      default:                        result_o = rem_s;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One radix-2 iteration per clock,
// XLEN iterations per operation; divide-by-zero and signed overflow can
// finish after a single iteration cycle when FAST_PATH is set.
// Ports:
//   clkIn      clock, rising edge
//   resetIn    asynchronous active-low reset
//   startIn    request, sampled only in IDLE
//   opIn       funct3 (MUL..REMU)
//   op1In      rs1 operand
//   op2In      rs2 operand
//   rdIn       destination register index
//   killIn     synchronous abort, wins over start and done
//   busyOut    high while CALC or DONE
//   doneOut    one-cycle result-valid / write-back enable
//   resultOut  result, held until the next completed operation
//   rdOut      destination index, held alongside resultOut
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter bit FAST_PATH = 1'b1
) (
  input  logic            clkIn,
  input  logic            resetIn,
  input  logic            startIn,
  input  logic [2:0]      opIn,
  input  logic [XLEN-1:0] op1In,
  input  logic [XLEN-1:0] op2In,
  input  logic [4:0]      rdIn,
  input  logic            killIn,
  output logic            busyOut,
  output logic            doneOut,
  output logic [XLEN-1:0] resultOut,
  output logic [4:0]      rdOut
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rdcap_q, rdcap_d;
  logic            neg_q, neg_d;
  logic            spec_q, spec_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  logic            start, step;
  logic            dp_neg, dp_special;
  logic [XLEN-1:0] dp_result;

  assign start = (state_q == ST_IDLE) && startIn && !killIn;
  // Special cases are preloaded with their answer; iterating would corrupt it.
  assign step  = (state_q == ST_CALC) && !spec_q && !killIn;

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk_i     (clkIn),
    .load_i    (start),
    .step_i    (step),
    .ld_op_i   (opIn),
    .op1_i     (op1In),
    .op2_i     (op2In),
    .op_i      (op_q),
    .neg_i     (neg_q),
    .neg_o     (dp_neg),
    .special_o (dp_special),
    .result_o  (dp_result)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rdcap_d  = rdcap_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          op_d    = opIn;
          rdcap_d = rdIn;
          neg_d   = dp_neg;
          spec_d  = dp_special;
        end
      end
      ST_CALC: begin
        if (killIn) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q == CNT_LAST) || (FAST_PATH && spec_q)) begin
            state_d  = ST_DONE;
            result_d = dp_result;
            rd_d     = rdcap_q;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rdcap_q  <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rdcap_q  <= rdcap_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busyOut   = (state_q != ST_IDLE);
  // A kill during the DONE cycle suppresses the write-back.
  assign doneOut   = (state_q == ST_DONE) && !killIn;
  assign resultOut = result_q;
  assign rdOut     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clkIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        startIn = 1'b0;
  logic        killIn = 1'b0;
  logic [2:0]  opIn = '0;
  logic [31:0] op1In = '0;
  logic [31:0] op2In = '0;
  logic [4:0]  rdIn = '0;
  logic        busyOut, doneOut;
  logic [31:0] resultOut;
  logic [4:0]  rdOut;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clkIn = ~clkIn;

  muldiv_unit #(.XLEN(32), .FAST_PATH(1'b1)) dut (
    .clkIn     (clkIn),
    .resetIn   (resetIn),
    .startIn   (startIn),
    .opIn      (opIn),
    .op1In     (op1In),
    .op2In     (op2In),
    .rdIn      (rdIn),
    .killIn    (killIn),
    .busyOut   (busyOut),
    .doneOut   (doneOut),
    .resultOut (resultOut),
    .rdOut     (rdOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request in cycle 0 and returns at the falling edge of cycle 1,
  // with the operand inputs scrambled so later cycles cannot depend on them.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(negedge clkIn);
    startIn = 1'b1; opIn = op; op1In = a; op2In = b; rdIn = rd;
    @(negedge clkIn);
    startIn = 1'b0; opIn = 3'd6; op1In = 32'hDEADBEEF; op2In = 32'h0000_0003; rdIn = 5'd31;
  endtask

  // Advances falling edges until doneOut, bounded; returns the cycle index.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (doneOut !== 1'b1 && cyc < 60) begin
      @(negedge clkIn);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int cyc;
    start_op(op, a, b, rd);
    chk({tag, " busy_c1"}, {31'b0, busyOut}, 32'd1);
    wait_done(1, cyc);
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " result"}, resultOut, exp);
    chk({tag, " rd"}, {27'b0, rdOut}, {27'b0, rd});
    @(negedge clkIn);
    chk({tag, " done_width"}, {31'b0, doneOut}, 32'd0);
    chk({tag, " busy_after"}, {31'b0, busyOut}, 32'd0);
  endtask

  initial begin
    int cyc;
    int pulses;

    // Reset state
    repeat (2) @(negedge clkIn);
    chk("rst busy", {31'b0, busyOut}, 32'd0);
    chk("rst done", {31'b0, doneOut}, 32'd0);
    chk("rst result", resultOut, 32'd0);
    chk("rst rd", {27'b0, rdOut}, 32'd0);
    resetIn = 1'b1;

    // Multiply group
    run_op("MUL 7*6",        OP_MUL,    32'd7,        32'd6,        5'd5,  32'd42,        33);
    run_op("MULHU max*max",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE,  33);
    run_op("MULH -1*2",      OP_MULH,   32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF,  33);
    run_op("MULHSU -1*max",  OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF,  33);
    run_op("MUL -3*5",       OP_MUL,    32'hFFFFFFFD, 32'd5,        5'd9,  32'hFFFFFFF1,  33);

    // Divide group
    run_op("DIV -7/2",       OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD,  33);
    run_op("REM -7/2",       OP_REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF,  33);
    run_op("DIVU 100/7",     OP_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,        33);
    run_op("REMU 100/7",     OP_REMU,   32'd100,      32'd7,        5'd13, 32'd2,         33);

    // Kill at cycle 10: back to IDLE, no write-back, outputs keep last result
    start_op(OP_MUL, 32'd3, 32'd4, 5'd20);
    repeat (9) @(negedge clkIn);
    killIn = 1'b1;
    @(negedge clkIn);
    killIn = 1'b0;
    chk("kill busy", {31'b0, busyOut}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clkIn);
      if (doneOut === 1'b1) pulses++;
    end
    chk("kill no_done", pulses, 0);
    chk("kill result_held", resultOut, 32'd2);
    chk("kill rd_held", {27'b0, rdOut}, 32'd13);

    run_op("DIV 7/-2",       OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD,  33);
    run_op("REM 7/-2",       OP_REM,    32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,         33);

    // Divide-by-zero and signed overflow take the short path
    run_op("DIVU 5/0",       OP_DIVU,   32'd5,        32'd0,        5'd16, 32'hFFFFFFFF,  2);
    run_op("REM 5/0",        OP_REM,    32'd5,        32'd0,        5'd17, 32'd5,         2);
    run_op("DIV -5/0",       OP_DIV,    32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFF,  2);
    run_op("REM -5/0",       OP_REM,    32'hFFFFFFFB, 32'd0,        5'd19, 32'hFFFFFFFB,  2);
    run_op("DIV ovf",        OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000,  2);
    run_op("REM ovf",        OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,         2);

    // startIn pulsed during CALC is ignored
    start_op(OP_MUL, 32'd3, 32'd4, 5'd4);
    repeat (4) @(negedge clkIn);
    startIn = 1'b1; opIn = OP_MUL; op1In = 32'd9; op2In = 32'd9; rdIn = 5'd9;
    @(negedge clkIn);
    startIn = 1'b0;
    wait_done(6, cyc);
    chk("ignore latency", cyc, 33);
    chk("ignore result", resultOut, 32'd12);
    chk("ignore rd", {27'b0, rdOut}, 32'd4);
    @(negedge clkIn);
    chk("ignore idle", {31'b0, busyOut}, 32'd0);

    // Reset asserted at cycle 15 of an operation
    start_op(OP_DIVU, 32'd100, 32'd7, 5'd23);
    repeat (14) @(negedge clkIn);
    resetIn = 1'b0;
    #1;
    chk("midrst busy", {31'b0, busyOut}, 32'd0);
    chk("midrst done", {31'b0, doneOut}, 32'd0);
    chk("midrst result", resultOut, 32'd0);
    chk("midrst rd", {27'b0, rdOut}, 32'd0);
    @(negedge clkIn);
    resetIn = 1'b1;
    run_op("post-rst MUL 7*6", OP_MUL, 32'd7, 32'd6, 5'd24, 32'd42, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
